// File: rtl/pe_chain_ctrl.sv
// Sequencer and result collector for a linear chain of PE multiply-accumulate cells.
// Optional abort input is enabled by defining PE_CHAIN_CTRL_ABORT_EN.
module pe_chain_ctrl #(
   parameter int unsigned N     = 4,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned K_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
`ifdef PE_CHAIN_CTRL_ABORT_EN
   input  logic               abort,
`endif
   input  logic               start,
   input  logic [K_W-1:0]     k_len,
   output logic               busy,
   output logic               done,
   output logic [2*N-1:0]     ctl_bus,
   output logic               feed_en,
   input  logic [WIDTH-1:0]   chain_in,
   output logic [WIDTH-1:0]   m_data,
   output logic [3:0]         m_idx,
   output logic               m_valid,
   input  logic               m_ready
);

   localparam int unsigned CW = K_W + 1;
   localparam int unsigned EW = K_W + 6;
   localparam int unsigned JW = 5;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_COMPUTE = 3'd2;
   localparam logic [2:0] S_DRAIN   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam logic [2*N-1:0] CTL_CLR = '0;
   localparam logic [2*N-1:0] CTL_ACC = {N{2'b10}};

   logic [2:0]        r_state, w_nxt_state;
   logic [K_W-1:0]    r_k, w_nxt_k;
   logic [CW-1:0]     r_c, w_nxt_c;
   logic [JW-1:0]     r_j, w_nxt_j;
   logic [2*N-1:0]    r_ctl, w_nxt_ctl;
   logic              r_feed, w_nxt_feed;
   logic              r_busy, w_nxt_busy;
   logic              r_done, w_nxt_done;
   logic [WIDTH-1:0]  r_m_data, w_nxt_m_data;
   logic [3:0]        r_m_idx, w_nxt_m_idx;
   logic              r_m_valid, w_nxt_m_valid;

   logic [EW-1:0]     w_span;
   logic [CW-1:0]     w_c_inc;
   logic [JW-1:0]     w_j_inc;
   logic              w_last_c;
   logic              w_slot_free;
   logic              w_load;

   // PE j reads out its accumulator, all others keep passing i_out through
   function automatic logic [2*N-1:0] ctl_sel(input logic [JW-1:0] j);
      logic [2*N-1:0] v;
      v = '0;
      for (int unsigned p = 0; p < N; p++)
         v[2*p +: 2] = (JW'(p) == j) ? 2'd1 : 2'd2;
      return v;
   endfunction

   assign w_span      = EW'(r_k) + EW'(N - 1);
   assign w_c_inc     = r_c + CW'(1);
   assign w_j_inc     = r_j + JW'(1);
   assign w_last_c    = (EW'(w_c_inc) == w_span);
   assign w_slot_free = !r_m_valid || m_ready;
   assign w_load      = (r_j < JW'(N)) && w_slot_free;

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_k       = r_k;
      w_nxt_c       = r_c;
      w_nxt_j       = r_j;
      w_nxt_ctl     = r_ctl;
      w_nxt_feed    = r_feed;
      w_nxt_done    = 1'b0;
      w_nxt_m_data  = r_m_data;
      w_nxt_m_idx   = r_m_idx;
      w_nxt_m_valid = r_m_valid;

      case (r_state)
         S_IDLE: begin
            w_nxt_ctl  = CTL_CLR;
            w_nxt_feed = 1'b0;
            if (start) begin
               w_nxt_k     = k_len;
               w_nxt_c     = '0;
               w_nxt_state = S_CLEAR;
            end
         end
         S_CLEAR: begin
            w_nxt_c = '0;
            if (w_span == '0) begin
               w_nxt_state = S_DRAIN;
               w_nxt_j     = '0;
               w_nxt_ctl   = ctl_sel('0);
               w_nxt_feed  = 1'b0;
            end else begin
               w_nxt_state = S_COMPUTE;
               w_nxt_ctl   = CTL_ACC;
               w_nxt_feed  = (r_k != '0);
            end
         end
         S_COMPUTE: begin
            // Extra N-1 cycles let the last operand ripple down to PE N-1
            if (w_last_c) begin
               w_nxt_state = S_DRAIN;
               w_nxt_j     = '0;
               w_nxt_ctl   = ctl_sel('0);
               w_nxt_feed  = 1'b0;
            end else begin
               w_nxt_c    = w_c_inc;
               w_nxt_feed = (w_c_inc < CW'(r_k));
            end
         end
         S_DRAIN: begin
            w_nxt_feed = 1'b0;
            if (w_load) begin
               w_nxt_m_data  = chain_in;
               w_nxt_m_idx   = 4'(r_j);
               w_nxt_m_valid = 1'b1;
               w_nxt_j       = w_j_inc;
               w_nxt_ctl     = ctl_sel(w_j_inc);
            end else if (r_j >= JW'(N) && w_slot_free) begin
               w_nxt_m_valid = 1'b0;
               w_nxt_state   = S_DONE;
               w_nxt_ctl     = CTL_CLR;
               w_nxt_done    = 1'b1;
               w_nxt_j       = '0;
            end
         end
         S_DONE: begin
            w_nxt_state = S_IDLE;
            w_nxt_ctl   = CTL_CLR;
            w_nxt_j     = '0;
         end
         default: begin
            w_nxt_state   = S_IDLE;
            w_nxt_ctl     = CTL_CLR;
            w_nxt_feed    = 1'b0;
            w_nxt_m_valid = 1'b0;
            w_nxt_j       = '0;
         end
      endcase

`ifdef PE_CHAIN_CTRL_ABORT_EN
      if (abort && r_state != S_IDLE) begin
         w_nxt_state   = S_IDLE;
         w_nxt_ctl     = CTL_CLR;
         w_nxt_feed    = 1'b0;
         w_nxt_m_valid = 1'b0;
         w_nxt_done    = 1'b0;
         w_nxt_j       = '0;
         w_nxt_c       = '0;
      end
`endif

      w_nxt_busy = (w_nxt_state != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_k       <= '0;
         r_c       <= '0;
         r_j       <= '0;
         r_ctl     <= '0;
         r_feed    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_m_data  <= '0;
         r_m_idx   <= '0;
         r_m_valid <= 1'b0;
      end else begin
         r_state   <= w_nxt_state;
         r_k       <= w_nxt_k;
         r_c       <= w_nxt_c;
         r_j       <= w_nxt_j;
         r_ctl     <= w_nxt_ctl;
         r_feed    <= w_nxt_feed;
         r_busy    <= w_nxt_busy;
         r_done    <= w_nxt_done;
         r_m_data  <= w_nxt_m_data;
         r_m_idx   <= w_nxt_m_idx;
         r_m_valid <= w_nxt_m_valid;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign ctl_bus = r_ctl;
   assign feed_en = r_feed;
   assign m_data  = r_m_data;
   assign m_idx   = r_m_idx;
   assign m_valid = r_m_valid;

endmodule

// File: tb/tb_pe_chain_ctrl.sv
// Directed bench for pe_chain_ctrl with a small behavioural PE chain (PE j computes acc += in*(w+j)).
module tb_pe_chain_ctrl;

   localparam int unsigned N   = 4;
   localparam int unsigned W   = 8;
   localparam int unsigned K_W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [K_W-1:0] k_len;
   logic           busy, done, feed_en, m_valid, m_ready;
   logic [2*N-1:0] ctl_bus;
   logic [W-1:0]   chain_in, m_data;
   logic [3:0]     m_idx;
   logic           abort;

   pe_chain_ctrl #(.N(N), .WIDTH(W), .K_W(K_W)) dut (
      .clk      (clk),
      .rst      (rst),
`ifdef PE_CHAIN_CTRL_ABORT_EN
      .abort    (abort),
`endif
      .start    (start),
      .k_len    (k_len),
      .busy     (busy),
      .done     (done),
      .ctl_bus  (ctl_bus),
      .feed_en  (feed_en),
      .chain_in (chain_in),
      .m_data   (m_data),
      .m_idx    (m_idx),
      .m_valid  (m_valid),
      .m_ready  (m_ready)
   );

   always #5 clk = ~clk;

   // PE chain model: operands shift one PE per cycle, readout walks from PE N-1 toward PE 0
   logic [W-1:0] a_tab [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
   logic [W-1:0] b_tab [8] = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11};
   logic [2:0]   fcnt = '0;
   logic [W-1:0] acc [N];
   logic [W-1:0] oin [N];
   logic [W-1:0] ow  [N];
   logic [W-1:0] pin [N];
   logic [W-1:0] pw  [N];
   logic [W-1:0] v_chain;

   always_comb begin
      pin[0] = feed_en ? a_tab[fcnt] : '0;
      pw[0]  = feed_en ? b_tab[fcnt] : '0;
      for (int j = 1; j < N; j++) begin
         pin[j] = oin[j-1];
         pw[j]  = ow[j-1];
      end
      v_chain = '0;
      for (int j = N - 1; j >= 0; j--) begin
         case (ctl_bus[2*j +: 2])
            2'd1:    v_chain = acc[j];
            2'd2:    v_chain = v_chain;
            default: v_chain = '0;
         endcase
      end
   end
   assign chain_in = v_chain;

   always_ff @(posedge clk) begin
      if (feed_en)              fcnt <= fcnt + 3'd1;
      else if (ctl_bus == '0)   fcnt <= '0;
      for (int j = 0; j < N; j++) begin
         oin[j] <= pin[j];
         ow[j]  <= pw[j];
         case (ctl_bus[2*j +: 2])
            2'd0:    acc[j] <= '0;
            2'd2:    acc[j] <= acc[j] + W'(pin[j] * (pw[j] + W'(j)));
            default: acc[j] <= acc[j];
         endcase
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
      end
   endtask

   logic [2*N-1:0] s_ctl   [40];
   logic           s_feed  [40];
   logic           s_busy  [40];
   logic           s_valid [40];
   logic [3:0]     s_idx   [40];
   logic [W-1:0]   s_data  [40];
   int             b_idx   [16];
   int             b_dat   [16];
   int             b_cyc   [16];
   int             nb, ndone, done_c, nfeed;

   // Cycle c is the interval after the c-th rising edge counted from the start-sampling edge
   task automatic run(input int k, input int n, input int lo, input int hi,
                      input bit hold, input int ab);
      nb = 0; ndone = 0; done_c = -1; nfeed = 0;
      for (int i = 0; i < 16; i++) begin
         b_idx[i] = -1; b_dat[i] = -1; b_cyc[i] = -1;
      end
      m_ready = 1'b1;
      k_len   = K_W'(k);
      start   = 1'b1;
      for (int c = 1; c <= n; c++) begin
         @(posedge clk); #1;
         if (hold) k_len = 8'd7;
         else      start = 1'b0;
         m_ready = !(c >= lo && c <= hi);
         abort   = (c == ab);
         s_ctl[c]   = ctl_bus;
         s_feed[c]  = feed_en;
         s_busy[c]  = busy;
         s_valid[c] = m_valid;
         s_idx[c]   = m_idx;
         s_data[c]  = m_data;
         if (m_valid && m_ready && nb < 16) begin
            b_idx[nb] = int'(m_idx);
            b_dat[nb] = int'(m_data);
            b_cyc[nb] = c;
            nb++;
         end
         if (done) begin
            ndone++;
            if (done_c < 0) done_c = c;
         end
         if (feed_en) nfeed++;
      end
      start   = 1'b0;
      m_ready = 1'b1;
      abort   = 1'b0;
   endtask

   task automatic chk_beats(input string tag, input int first_cyc, input int base, input int step);
      chk({tag, "_nbeats"}, 32'(nb), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_idx%0d", tag, i),  32'(b_idx[i]), 32'(i));
         chk($sformatf("%s_data%0d", tag, i), 32'(b_dat[i]), 32'(base + step * i));
         chk($sformatf("%s_cyc%0d", tag, i),  32'(b_cyc[i]), 32'(first_cyc + i));
      end
   endtask

   initial begin
      int cnt;
      rst = 1'b0; start = 1'b0; k_len = '0; m_ready = 1'b1; abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctl",   32'(ctl_bus), 32'h0);
      chk("rst_busy",  32'(busy),    32'h0);
      chk("rst_done",  32'(done),    32'h0);
      chk("rst_feed",  32'(feed_en), 32'h0);
      chk("rst_valid", 32'(m_valid), 32'h0);
      chk("rst_data",  32'(m_data),  32'h0);
      chk("rst_idx",   32'(m_idx),   32'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Reset asserted in the middle of COMPUTE
      start = 1'b1; k_len = 8'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_pre_ctl", 32'(ctl_bus), 32'hAA);
      rst = 1'b0;
      #1;
      chk("midrst_ctl",   32'(ctl_bus), 32'h0);
      chk("midrst_busy",  32'(busy),    32'h0);
      chk("midrst_valid", 32'(m_valid), 32'h0);
      @(posedge clk); #1;
      chk("midrst_ctl2",  32'(ctl_bus), 32'h0);
      chk("midrst_busy2", 32'(busy),    32'h0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Nominal run, K=3: PE j holds 1*(4+j)+2*(5+j)+3*(6+j) = 32+6j
      run(3, 16, -1, -1, 1'b0, -1);
      chk("main_clear_ctl",  32'(s_ctl[1]),  32'h0);
      chk("main_clear_busy", 32'(s_busy[1]), 32'h1);
      chk("main_clear_feed", 32'(s_feed[1]), 32'h0);
      cnt = 0;
      for (int c = 2; c <= 7; c++) if (s_ctl[c] == 8'hAA) cnt++;
      chk("main_compute_len", 32'(cnt), 32'd6);
      chk("main_drain_ctl0",  32'(s_ctl[8]),  32'hA9);
      chk("main_feed_cnt",    32'(nfeed),     32'd3);
      chk("main_feed_first",  32'(s_feed[2]), 32'h1);
      chk("main_feed_last",   32'(s_feed[4]), 32'h1);
      chk("main_feed_off",    32'(s_feed[5]), 32'h0);
      chk_beats("main", 9, 32, 6);
      chk("main_done_cnt",  32'(ndone),      32'd1);
      chk("main_done_cyc",  32'(done_c),     32'd13);
      chk("main_done_ctl",  32'(s_ctl[13]),  32'h0);
      chk("main_done_busy", 32'(s_busy[13]), 32'h1);
      chk("main_idle_busy", 32'(s_busy[14]), 32'h0);

      // Backpressure while idx 0 is presented and PE 1 is selected
      run(3, 22, 9, 13, 1'b0, -1);
      cnt = 0;
      for (int c = 9; c <= 13; c++)
         if (s_valid[c] && s_idx[c] == 4'd0 && s_data[c] == 8'd32 && s_ctl[c] == 8'hA6) cnt++;
      chk("bp_hold_cycles", 32'(cnt), 32'd5);
      chk_beats("bp", 14, 32, 6);
      chk("bp_done_cyc", 32'(done_c), 32'd18);
      chk("bp_done_cnt", 32'(ndone),  32'd1);

      // K=0: N-1 zero-feed compute cycles, all results zero
      run(0, 14, -1, -1, 1'b0, -1);
      cnt = 0;
      for (int c = 2; c <= 4; c++) if (s_ctl[c] == 8'hAA) cnt++;
      chk("k0_compute_len", 32'(cnt),      32'd3);
      chk("k0_drain_ctl0",  32'(s_ctl[5]), 32'hA9);
      chk("k0_feed_cnt",    32'(nfeed),    32'd0);
      chk_beats("k0", 6, 0, 0);
      chk("k0_done_cyc", 32'(done_c), 32'd10);
      chk("k0_done_cnt", 32'(ndone),  32'd1);

      // start held high with k_len changing mid-run
      run(3, 16, -1, -1, 1'b1, -1);
      chk_beats("hold", 9, 32, 6);
      chk("hold_done_cyc",   32'(done_c),     32'd13);
      chk("hold_idle_busy",  32'(s_busy[14]), 32'h0);
      chk("hold_restart",    32'(s_busy[15]), 32'h1);
      chk("hold_restart_ctl",32'(s_ctl[15]),  32'h0);
      cnt = 0;
      for (int c = 0; c < 60 && cnt == 0; c++) begin
         @(posedge clk); #1;
         if (done) cnt = 1;
      end
      chk("hold_run2_done", 32'(cnt), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("hold_run2_idle", 32'(busy), 32'h0);

`ifdef PE_CHAIN_CTRL_ABORT_EN
      // Abort in DRAIN once idx 1 has been accepted
      run(3, 20, -1, -1, 1'b0, 11);
      chk("ab_idx1_acc", 32'(b_idx[1]),    32'd1);
      chk("ab_ctl",      32'(s_ctl[12]),   32'h0);
      chk("ab_valid",    32'(s_valid[12]), 32'h0);
      chk("ab_busy",     32'(s_busy[12]),  32'h0);
      chk("ab_no_done",  32'(ndone),       32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pe_chain_ctrl.md
Name: pe_chain_ctrl

Overview:
- Sequencer and result collector at the far end of a linear chain of PE multiply-accumulate cells.
- Drives each PE's 2-bit ctl code: 0 = clear, 1 = output own accumulator, 2 = accumulate / pass i_out through.
- Gates the operand feed into the chain.
- Drains accumulators one PE at a time through the combinational o_out chain into a registered valid/ready output stream.

Parameters:
- N, 4, number of PEs in the chain (1..16); PE 0's o_out connects to chain_in, PE j's i_out connects to PE j+1's o_out.
- WIDTH, 8, PE data width.
- K_W, 8, width of the k_len accumulation-length field.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to run one tile; sampled only in IDLE.
- k_len  input  K_W  number of operand beats to feed; sampled with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse in state DONE.
- ctl_bus  output  2*N  ctl code for PE j on bits [2j+1:2j].
- feed_en  output  1  high = upstream operands pass into the chain; low = the array wrapper forces i_in/i_w to zero.
- chain_in  input  WIDTH  o_out of PE 0.
- m_data  output  WIDTH  drained accumulator value.
- m_idx  output  4  PE index of m_data.
- m_valid  output  1  m_data/m_idx valid.
- m_ready  input  1  downstream accepts when high together with m_valid.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, ctl_bus all 0, feed_en 0, busy 0, done 0, m_valid 0, m_data 0, m_idx 0, counters 0.
- IDLE: ctl_bus all 0 (PEs held clear), feed_en 0. start=1 latches k_len into K and moves to CLEAR. start while busy is ignored.
- CLEAR: exactly 1 cycle, ctl_bus all 0, feed_en 0. Flushes the PE o_in/o_w pipeline to zero. Next state COMPUTE, cycle counter c=0.
- COMPUTE: ctl_bus all 2.
  - feed_en=1 while c<K, 0 afterwards.
  - Lasts K+N-1 cycles, so the last operand reaches PE N-1.
  - If K+N-1==0 (K=0, N=1), COMPUTE is skipped and CLEAR goes directly to DRAIN.
  - K=0 with N>1 runs N-1 zero-feed cycles; all results are 0.
- DRAIN: feed_en 0; read pointer j starts at 0.
  - ctl_bus: PE j = 1, every other PE = 2. Zero feed means mul=0, so accumulators stay stable under code 2.
  - The output register is loadable when m_valid=0 or m_ready=1. On a load: m_data<=chain_in, m_idx<=j, m_valid<=1, j<=j+1, and ctl_bus re-points to the new j in the same edge.
  - If not loadable (backpressure), j and ctl_bus hold indefinitely.
  - After PE N-1 is loaded, stay in DRAIN until that beat handshakes. Then m_valid<=0 and go to DONE.
  - A handshake with no new load clears m_valid.
- DONE: 1 cycle, done=1, ctl_bus all 0. Next state IDLE. busy drops in the cycle after DONE.
- Results emerge in order idx 0..N-1, one per handshake. Best-case throughput is 1 result per cycle.
- Counters:
  - c is K_W+1 bits wide; no wrap for K up to 2^K_W-1.
  - j wraps to 0 on DONE.
- Reset asserted mid-operation: immediate return to the reset values. Any in-flight m_valid beat is dropped without a handshake.

Optional Feature:
- Macro PE_CHAIN_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in any non-IDLE state forces IDLE on the next edge: ctl_bus all 0 (PE accumulators cleared), feed_en 0, m_valid 0, no done pulse.
  - abort has priority over every other transition. It is ignored in IDLE; start in the same cycle as abort in IDLE still starts a run.
- Undefined: no abort port; a run always completes through DONE.

Test Plan:
- Reset during COMPUTE with N=4, K=3 -> next cycle ctl_bus=0x00, busy=0, m_valid=0. A subsequent start runs normally.
- N=4, K=3, m_ready=1, bench PE model with chain_in = accumulator selected by ctl_bus:
  - CLEAR 1 cycle, then COMPUTE 6 cycles with feed_en high for exactly 3.
  - 4 results on consecutive cycles, idx 0,1,2,3, values match the model.
  - done pulses once; total start-to-done is 1+1+6+4+1 cycles.
- Backpressure, m_ready low for 5 cycles at idx 1 -> m_data/m_idx stable, ctl_bus keeps PE 1 at code 1. No idx skipped or duplicated once m_ready=1.
- K=0, N=4 -> COMPUTE 3 cycles with feed_en always 0; drained values all 0x00; done pulses.
- start held high during a run and k_len changed mid-run -> ignored; the run uses the latched K. A new run starts only from IDLE.
- ABORT_EN build: abort asserted in DRAIN after idx 1 accepted -> next cycle IDLE, ctl_bus=0, m_valid=0, done never pulses.
